// File: rtl/dnn_acc_ctrl.sv
`timescale 1ns/1ps
// AXI4-Lite control block for the DNN accelerator: one-cycle B/R response after accept, each held until bready/rready.
// Optional run-cycle counter guarded by DNN_ACC_CYCLE_CNT_EN (absent -> CYCLES reads 0).
module dnn_acc_ctrl (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        gpio_acc_start,
  input  logic        acc_done
);

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_CYCLES  = 4'h8;
  localparam logic [3:0] ADDR_SCRATCH = 4'hC;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        init_q;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] cycles_val;
  logic [31:0] rd_mux;
  logic        wr_acc, rd_acc, is_start, start_ok, complete;

  // Ready lines stay low after reset release until the first clock edge.
  assign s_axi_awready = init_q && (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign s_axi_wready  = s_axi_awready;
  assign s_axi_arready = init_q && (r_state_q == R_IDLE);
  assign wr_acc        = s_axi_awready;
  assign rd_acc        = s_axi_arready && s_axi_arvalid;

  assign is_start = wr_acc && (s_axi_awaddr == ADDR_CTRL) && s_axi_wstrb[0] && s_axi_wdata[0];
  assign start_ok = is_start && !busy_q;
  assign complete = busy_q && acc_done;

  assign s_axi_bvalid   = (w_state_q == W_RESP);
  assign s_axi_bresp    = bresp_q;
  assign s_axi_rvalid   = (r_state_q == R_DATA);
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = 2'b00;
  assign gpio_acc_start = busy_q;

  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (wr_acc) begin
        w_state_d = W_RESP;
        // A start while busy is rejected even when completion lands on the same edge.
        bresp_d   = (is_start && busy_q) ? 2'b10 : 2'b00;
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (rd_acc) begin
        r_state_d = R_DATA;
        rdata_d   = rd_mux;
      end
      R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    case (s_axi_araddr)
      ADDR_STATUS:  rd_mux = {30'd0, busy_q, done_q};
      ADDR_CYCLES:  rd_mux = cycles_val;
      ADDR_SCRATCH: rd_mux = scratch_q;
      default:      rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    busy_d    = busy_q;
    done_d    = done_q;
    scratch_d = scratch_q;
    if (complete) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (start_ok) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end
    if (wr_acc && (s_axi_awaddr == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi_wstrb[i]) scratch_d[8*i +: 8] = s_axi_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      init_q    <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= 2'b00;
      rdata_q   <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scratch_q <= 32'd0;
    end else begin
      init_q    <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scratch_q <= scratch_d;
    end
  end

`ifdef DNN_ACC_CYCLE_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (start_ok) cycles_d = 32'd0;
    else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) cycles_q <= 32'd0;
    else               cycles_q <= cycles_d;
  end

  assign cycles_val = cycles_q;
`else
  assign cycles_val = 32'd0;
`endif

endmodule

// File: doc/dnn_acc_ctrl.md
DNN_ACC_CTRL -- requirements
Module: dnn_acc_ctrl

Interface
REQ-001 SHALL provide user_clk, input, 1, the single clock; all logic is rising-edge.
REQ-002 SHALL provide user_reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide s_axi_awaddr/awvalid/awready, in/in/out, 4/1/1, AXI4-Lite write-address channel.
REQ-004 SHALL provide s_axi_wdata/wstrb/wvalid/wready, in/in/in/out, 32/4/1/1, AXI4-Lite write-data channel.
REQ-005 SHALL provide s_axi_bresp/bvalid/bready, out/out/in, 2/1/1, AXI4-Lite write-response channel.
REQ-006 SHALL provide s_axi_araddr/arvalid/arready, in/in/out, 4/1/1, AXI4-Lite read-address channel.
REQ-007 SHALL provide s_axi_rdata/rresp/rvalid/rready, out/out/out/in, 32/2/1/1, AXI4-Lite read-data channel.
REQ-008 SHALL provide gpio_acc_start, output, 1, level start request to the DNN accelerator.
REQ-009 SHALL provide acc_done, input, 1, registered completion flag from the DNN accelerator.

Function
REQ-010 Register map (word offsets): 0x0 CTRL (W: bit0 start), 0x4 STATUS (R: bit0 done, bit1 busy), 0x8 CYCLES (R: 32-bit run count), 0xC SCRATCH (R/W, 32-bit).
REQ-011 Write FSM states W_IDLE, W_RESP; in W_IDLE awready=wready=1 only when awvalid&&wvalid both high; both channels accepted in the same cycle.
REQ-012 On accept, FSM enters W_RESP next cycle with bvalid=1; bvalid/bresp held stable until bready, then return to W_IDLE.
REQ-013 Read FSM states R_IDLE, R_DATA; arready=1 in R_IDLE; on accept, rvalid=1 next cycle with rdata/rresp registered, held stable until rready.
REQ-014 Read and write FSMs operate independently; simultaneous read and write accepted in the same cycle.
REQ-015 Unmapped or read-only-target writes: no state change, bresp=2'b00; reads of CTRL return 0; rresp always 2'b00.
REQ-016 SCRATCH writes honour wstrb per byte.
REQ-017 CTRL write with wstrb[0]=1, wdata[0]=1 while busy=0: busy<=1, done<=0, gpio_acc_start<=1, CYCLES<=0, bresp=2'b00.
REQ-018 CTRL start write while busy=1: ignored, bresp=2'b10 (SLVERR).
REQ-019 While busy=1 and acc_done=1 sampled: busy<=0, done<=1 (sticky), gpio_acc_start<=0 on the next edge.
REQ-020 Start write and acc_done=1 in the same cycle while busy=1: completion wins, start rejected with SLVERR.
REQ-021 acc_done=1 while busy=0: ignored.
REQ-022 STATUS read returns values as of the accept cycle (registered at arvalid&&arready).

Reset
REQ-023 On user_reset_n=0, immediately: both FSMs idle, awready=wready=arready=0 until first edge after release, bvalid=rvalid=0, bresp=rresp=0, rdata=0, gpio_acc_start=0, busy=done=0, CYCLES=0, SCRATCH=0.
REQ-024 Reset mid-transaction drops the outstanding response; no response issued after release.

Configuration
REQ-025 Macro DNN_ACC_CYCLE_CNT_EN: defined -> CYCLES increments by 1 each cycle busy=1, saturating at 32'hFFFF_FFFF; undefined -> counter not built, offset 0x8 reads 0.

Verification
REQ-026 Reset, read 0x4 -> rdata=0, rresp=0; gpio_acc_start=0.
REQ-027 Write 0x0 data 1 strb 4'h1 -> bresp=0 one cycle after accept; gpio_acc_start=1; STATUS reads 32'h2.
REQ-028 Drive acc_done=1 after 100 busy cycles -> gpio_acc_start=0 next edge; STATUS=32'h1; CYCLES=100 (with macro) or 0 (without).
REQ-029 Second start while busy -> bresp=2'b10, CYCLES not cleared, busy stays 1.
REQ-030 Write 0xC data 32'hA5A5_A5A5 strb 4'b0101 from 0 -> read 0xC = 32'h00A5_00A5; bready held low 5 cycles -> bvalid stable.
REQ-031 Assert user_reset_n=0 during W_RESP -> bvalid=0 immediately, no B beat after release.
